// File: rtl/utf8_mark_feeder.sv
// utf8_mark_feeder: decodes a UTF-8 byte stream into codepoints, issues one
// mark_for_codepoint lookup call per codepoint, and presents the
// {codepoint, mark, error} result downstream. Malformed sequences yield
// REPLACEMENT with out_error set, and they bump a saturating error counter.
module utf8_mark_feeder #(
    parameter int unsigned ERR_CNT_W   = 16,
    parameter logic [31:0] REPLACEMENT = 32'h0000FFFD
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [7:0]           in_data,
    output logic                 call_start,
    input  logic                 call_busy,
    output logic [31:0]          call_c,
    input  logic                 ret_done,
    output logic                 ret_stall,
    input  logic [31:0]          ret_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_codepoint,
    output logic [31:0]          out_mark,
    output logic                 out_error,
    output logic [ERR_CNT_W-1:0] err_count
);

    typedef enum logic [2:0] {
        LEAD,
        CONT,
        CALL,
        WAIT,
        OUT
    } state_t;

    state_t      state;
    logic        replay;       // a truncating byte is waiting to be decoded as a lead
    logic [7:0]  replay_byte;
    logic [20:0] acc;          // codepoint bits gathered so far
    logic [1:0]  need;         // continuation bytes still expected
    logic [2:0]  len;          // total sequence length, for the overlong check
    logic [31:0] cp;           // codepoint to be issued on the call interface
    logic        err;          // current codepoint came from a malformed sequence

    // Error counter increment that sticks at all-ones.
    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + ERR_CNT_W'(1);
    endfunction

    logic [7:0]  lead_byte;
    logic        lead_take;
    logic        cont_take;
    logic        is_cont;
    logic [20:0] acc_next;
    logic        final_bad;
    logic [1:0]  lead_need;
    logic [20:0] lead_acc;
    logic        lead_bad;

    // A pending replay byte is decoded without waiting for the input port.
    assign lead_byte = replay ? replay_byte : in_data;
    assign lead_take = (state == LEAD) && (replay || (in_valid && in_ready));
    assign cont_take = (state == CONT) && in_valid && in_ready;
    assign is_cont   = (in_data[7:6] == 2'b10);
    assign acc_next  = 21'({acc, in_data[5:0]});

    // Completed sequence is rejected if overlong, a surrogate, or beyond U+10FFFF.
    assign final_bad = ((len == 3'd3) && (acc_next < 21'h000800)) ||
                       ((len == 3'd4) && (acc_next < 21'h010000)) ||
                       ((acc_next >= 21'h00D800) && (acc_next <= 21'h00DFFF)) ||
                       (acc_next > 21'h10FFFF);

    // Classify the lead byte: sequence length and the payload bits it carries.
    always_comb begin
        lead_need = 2'd0;
        lead_acc  = 21'd0;
        lead_bad  = 1'b0;
        if (lead_byte[7] == 1'b0) begin
            lead_acc = {14'd0, lead_byte[6:0]};
        end else if ((lead_byte >= 8'hC2) && (lead_byte <= 8'hDF)) begin
            lead_need = 2'd1;
            lead_acc  = {16'd0, lead_byte[4:0]};
        end else if ((lead_byte >= 8'hE0) && (lead_byte <= 8'hEF)) begin
            lead_need = 2'd2;
            lead_acc  = {17'd0, lead_byte[3:0]};
        end else if ((lead_byte >= 8'hF0) && (lead_byte <= 8'hF4)) begin
            lead_need = 2'd3;
            lead_acc  = {18'd0, lead_byte[2:0]};
        end else begin
            lead_bad = 1'b1;
        end
    end

    // Decode / call / wait / present sequencer with registered outputs.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state         <= LEAD;
            in_ready      <= 1'b0;
            call_start    <= 1'b0;
            call_c        <= 32'd0;
            ret_stall     <= 1'b1;
            out_valid     <= 1'b0;
            out_codepoint <= 32'd0;
            out_mark      <= 32'd0;
            out_error     <= 1'b0;
            err_count     <= '0;
            replay        <= 1'b0;
            replay_byte   <= 8'd0;
            acc           <= 21'd0;
            need          <= 2'd0;
            len           <= 3'd0;
            cp            <= 32'd0;
            err           <= 1'b0;
        end else begin
            case (state)
                LEAD: begin
                    if (lead_take) begin
                        replay <= 1'b0;
                        if (lead_bad) begin
                            cp         <= REPLACEMENT;
                            call_c     <= REPLACEMENT;
                            err        <= 1'b1;
                            err_count  <= sat_inc(err_count);
                            call_start <= 1'b1;
                            in_ready   <= 1'b0;
                            state      <= CALL;
                        end else if (lead_need == 2'd0) begin
                            cp         <= {24'd0, lead_byte};
                            call_c     <= {24'd0, lead_byte};
                            err        <= 1'b0;
                            call_start <= 1'b1;
                            in_ready   <= 1'b0;
                            state      <= CALL;
                        end else begin
                            acc      <= lead_acc;
                            need     <= lead_need;
                            len      <= {1'b0, lead_need} + 3'd1;
                            err      <= 1'b0;
                            in_ready <= 1'b1;
                            state    <= CONT;
                        end
                    end else begin
                        in_ready <= 1'b1;
                    end
                end

                CONT: begin
                    if (cont_take) begin
                        if (is_cont) begin
                            acc  <= acc_next;
                            need <= need - 2'd1;
                            if (need == 2'd1) begin
                                if (final_bad) begin
                                    cp        <= REPLACEMENT;
                                    call_c    <= REPLACEMENT;
                                    err       <= 1'b1;
                                    err_count <= sat_inc(err_count);
                                end else begin
                                    cp     <= {11'd0, acc_next};
                                    call_c <= {11'd0, acc_next};
                                    err    <= 1'b0;
                                end
                                call_start <= 1'b1;
                                in_ready   <= 1'b0;
                                state      <= CALL;
                            end
                        end else begin
                            // Truncated sequence: the interrupting byte starts the next one.
                            replay      <= 1'b1;
                            replay_byte <= in_data;
                            cp          <= REPLACEMENT;
                            call_c      <= REPLACEMENT;
                            err         <= 1'b1;
                            err_count   <= sat_inc(err_count);
                            call_start  <= 1'b1;
                            in_ready    <= 1'b0;
                            state       <= CALL;
                        end
                    end
                end

                CALL: begin
                    if (!call_busy) begin
                        call_start <= 1'b0;
                        ret_stall  <= 1'b0;
                        state      <= WAIT;
                    end
                end

                WAIT: begin
                    if (ret_done) begin
                        ret_stall     <= 1'b1;
                        out_mark      <= ret_data;
                        out_codepoint <= cp;
                        out_error     <= err;
                        out_valid     <= 1'b1;
                        state         <= OUT;
                    end
                end

                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= ~replay;
                        state     <= LEAD;
                    end
                end

                default: begin
                    state <= LEAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_utf8_mark_feeder.sv
// Directed bench for utf8_mark_feeder with a 3-bit error counter so that
// saturation is reachable in a short run.
module tb_utf8_mark_feeder;

    localparam int ERR_CNT_W = 3;

    logic                 clock = 1'b0;
    logic                 resetn = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [7:0]           in_data = 8'd0;
    logic                 call_start;
    logic                 call_busy = 1'b0;
    logic [31:0]          call_c;
    logic                 ret_done = 1'b1;
    logic                 ret_stall;
    logic [31:0]          ret_data = 32'd0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [31:0]          out_codepoint;
    logic [31:0]          out_mark;
    logic                 out_error;
    logic [ERR_CNT_W-1:0] err_count;

    int checks = 0;
    int failures = 0;
    int calls = 0;
    int calls0 = 0;

    utf8_mark_feeder #(
        .ERR_CNT_W   (ERR_CNT_W),
        .REPLACEMENT (32'h0000FFFD)
    ) dut (
        .clock         (clock),
        .resetn        (resetn),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .call_start    (call_start),
        .call_busy     (call_busy),
        .call_c        (call_c),
        .ret_done      (ret_done),
        .ret_stall     (ret_stall),
        .ret_data      (ret_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_codepoint (out_codepoint),
        .out_mark      (out_mark),
        .out_error     (out_error),
        .err_count     (err_count)
    );

    always #5 clock = ~clock;

    // Count accepted calls on the lookup interface.
    always @(posedge clock) begin
        if (resetn && call_start && !call_busy) calls <= calls + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic timed_out(input string tag);
        checks++;
        failures++;
        $error("FAIL %s observed=timeout expected=event", tag);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clock);
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (n >= 200) timed_out("send_byte");
        @(posedge clock);
        #1 in_valid = 1'b0;
    endtask

    task automatic expect_result(input string tag, input logic [31:0] ecp,
                                 input logic [31:0] mark, input logic eerr);
        int n;
        ret_data = mark;
        n = 0;
        @(negedge clock);
        while (call_start !== 1'b1 && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (n >= 200) timed_out({tag, "_call"});
        else begin
            chk({tag, "_call_c"}, call_c, ecp);
            chk({tag, "_inrdy_call"}, in_ready, 32'd0);
        end
        n = 0;
        while (out_valid !== 1'b1 && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (n >= 200) timed_out({tag, "_out"});
        else begin
            chk({tag, "_cp"}, out_codepoint, ecp);
            chk({tag, "_mark"}, out_mark, mark);
            chk({tag, "_err"}, out_error, eerr);
            chk({tag, "_inrdy_out"}, in_ready, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clock);
        #1 out_ready = 1'b0;
    endtask

    initial begin
        int n;

        // Reset values
        repeat (2) @(negedge clock);
        chk("rst_in_ready", in_ready, 32'd0);
        chk("rst_call_start", call_start, 32'd0);
        chk("rst_call_c", call_c, 32'd0);
        chk("rst_ret_stall", ret_stall, 32'd1);
        chk("rst_out_valid", out_valid, 32'd0);
        chk("rst_err_count", err_count, 32'd0);
        resetn = 1'b1;
        @(negedge clock);
        chk("post_rst_in_ready", in_ready, 32'd1);

        // ASCII with exact minimum latency
        ret_data = 32'h3;
        send_byte(8'h41);
        @(negedge clock);
        chk("lat_call_start", call_start, 32'd1);
        chk("lat_call_c", call_c, 32'h41);
        @(negedge clock);
        chk("lat_wait_stall", ret_stall, 32'd0);
        chk("lat_wait_ovalid", out_valid, 32'd0);
        @(negedge clock);
        chk("lat_out_valid", out_valid, 32'd1);
        chk("lat_out_cp", out_codepoint, 32'h41);
        chk("lat_out_mark", out_mark, 32'h3);
        chk("lat_out_err", out_error, 32'd0);
        out_ready = 1'b1;
        @(posedge clock);
        #1 out_ready = 1'b0;

        // Valid multi-byte sequences
        send_byte(8'hC3);
        send_byte(8'hA9);
        expect_result("two_byte", 32'hE9, 32'h10, 1'b0);
        send_byte(8'hF0);
        send_byte(8'h9F);
        send_byte(8'h98);
        send_byte(8'h80);
        expect_result("four_byte", 32'h1F600, 32'h20, 1'b0);
        chk("valid_err_count", err_count, 32'd0);

        // Invalid lead bytes and a surrogate
        send_byte(8'hC0);
        expect_result("c0", 32'hFFFD, 32'h30, 1'b1);
        send_byte(8'h80);
        expect_result("stray80", 32'hFFFD, 32'h31, 1'b1);
        chk("c0_80_err_count", err_count, 32'd2);
        send_byte(8'hED);
        send_byte(8'hA0);
        send_byte(8'h80);
        expect_result("surrogate", 32'hFFFD, 32'h32, 1'b1);
        chk("surrogate_err_count", err_count, 32'd3);

        // Truncation followed by replay of the interrupting byte
        send_byte(8'hE2);
        send_byte(8'h82);
        send_byte(8'h41);
        expect_result("trunc", 32'hFFFD, 32'h40, 1'b1);
        @(negedge clock);
        chk("replay_in_ready", in_ready, 32'd0);
        expect_result("replay", 32'h41, 32'h41, 1'b0);
        @(negedge clock);
        chk("after_replay_in_ready", in_ready, 32'd1);
        chk("trunc_err_count", err_count, 32'd4);

        // More malformed input, driving the counter into saturation
        send_byte(8'hFF);
        expect_result("ff", 32'hFFFD, 32'h50, 1'b1);
        send_byte(8'hF5);
        expect_result("f5", 32'hFFFD, 32'h51, 1'b1);
        chk("err_count_6", err_count, 32'd6);
        send_byte(8'hC1);
        expect_result("c1", 32'hFFFD, 32'h52, 1'b1);
        chk("err_count_7", err_count, 32'd7);
        send_byte(8'hE0);
        send_byte(8'h80);
        send_byte(8'h80);
        expect_result("overlong3", 32'hFFFD, 32'h53, 1'b1);
        send_byte(8'hF4);
        send_byte(8'h90);
        send_byte(8'h80);
        send_byte(8'h80);
        expect_result("above_max", 32'hFFFD, 32'h54, 1'b1);
        chk("err_count_sat", err_count, 32'd7);

        // Lookup busy for 5 cycles, consumer stalls for 4 cycles
        calls0 = calls;
        call_busy = 1'b1;
        ret_data = 32'h55;
        send_byte(8'h7A);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("busy_call_start", call_start, 32'd1);
            chk("busy_call_c", call_c, 32'h7A);
            chk("busy_in_ready", in_ready, 32'd0);
        end
        call_busy = 1'b0;
        n = 0;
        @(negedge clock);
        while (out_valid !== 1'b1 && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (n >= 200) timed_out("stall_out");
        for (int i = 0; i < 4; i++) begin
            chk("stall_out_valid", out_valid, 32'd1);
            chk("stall_out_cp", out_codepoint, 32'h7A);
            chk("stall_out_mark", out_mark, 32'h55);
            chk("stall_out_err", out_error, 32'd0);
            chk("stall_in_ready", in_ready, 32'd0);
            @(negedge clock);
        end
        out_ready = 1'b1;
        @(posedge clock);
        #1 out_ready = 1'b0;
        chk("busy_one_call", calls - calls0, 32'd1);

        // Reset while waiting on the lookup; late ret_done must be ignored
        ret_done = 1'b0;
        ret_data = 32'h99;
        send_byte(8'h42);
        n = 0;
        @(negedge clock);
        while (ret_stall !== 1'b0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (n >= 200) timed_out("reach_wait");
        resetn = 1'b0;
        #1;
        chk("mid_rst_ret_stall", ret_stall, 32'd1);
        chk("mid_rst_out_valid", out_valid, 32'd0);
        chk("mid_rst_call_start", call_start, 32'd0);
        chk("mid_rst_call_c", call_c, 32'd0);
        chk("mid_rst_cp", out_codepoint, 32'd0);
        chk("mid_rst_mark", out_mark, 32'd0);
        chk("mid_rst_err", out_error, 32'd0);
        chk("mid_rst_err_count", err_count, 32'd0);
        chk("mid_rst_in_ready", in_ready, 32'd0);
        ret_done = 1'b1;
        @(negedge clock);
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("late_done_out_valid", out_valid, 32'd0);
            chk("late_done_ret_stall", ret_stall, 32'd1);
            chk("late_done_call_start", call_start, 32'd0);
        end
        send_byte(8'h43);
        expect_result("after_rst", 32'h43, 32'h77, 1'b0);
        chk("after_rst_err_count", err_count, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/utf8_mark_feeder.md
Name: utf8_mark_feeder

Overview:
- Upstream stage of the mark_for_codepoint lookup.
- Accepts a UTF-8 byte stream and decodes it into 32-bit Unicode codepoints.
- Issues one call per codepoint on the lookup's call interface (start/busy/c), collects returndata on the return interface (done/stall), and presents the {codepoint, mark, error} result to the downstream consumer.
- Exactly one call outstanding at a time.

Parameters:
- ERR_CNT_W, 16, width of the saturating decode-error counter.
- REPLACEMENT, 32'h0000FFFD, codepoint issued for any malformed sequence.

Ports:
- clock  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- in_valid  in  1  input byte valid.
- in_ready  out  1  input byte accepted when in_valid & in_ready.
- in_data  in  8  UTF-8 byte.
- call_start  out  1  to lookup start.
- call_busy  in  1  from lookup busy; call accepted when call_start & ~call_busy.
- call_c  out  32  to lookup c.
- ret_done  in  1  from lookup done.
- ret_stall  out  1  to lookup stall; result consumed when ret_done & ~ret_stall.
- ret_data  in  32  from lookup returndata.
- out_valid  out  1  result valid.
- out_ready  in  1  result taken when out_valid & out_ready.
- out_codepoint  out  32  decoded codepoint (or REPLACEMENT).
- out_mark  out  32  lookup result.
- out_error  out  1  result came from a malformed sequence.
- err_count  out  ERR_CNT_W  saturating count of malformed sequences.

Behaviour:
- Reset (async, resetn=0): state=LEAD, in_ready=0 during reset then 1; call_start=0; call_c=0; ret_stall=1; out_valid=0; out_codepoint/out_mark=0; out_error=0; err_count=0; replay flag cleared. Reset mid-call abandons it; a late ret_done is ignored because ret_stall=1 outside WAIT.
- States: LEAD, CONT, CALL, WAIT, OUT.
- LEAD: in_ready = ~replay. Byte source is the replay register if the replay flag is set, otherwise the accepted input byte.
  - 0x00-0x7F: cp=byte, go to CALL.
  - 0xC2-0xDF: need=1. 0xE0-0xEF: need=2. 0xF0-0xF4: need=3. Load payload bits, go to CONT.
  - 0x80-0xBF, 0xC0, 0xC1, 0xF5-0xFF: error, cp=REPLACEMENT, go to CALL.
- CONT: in_ready=1.
  - Byte 10xxxxxx: acc = (acc<<6)|low6, need-1. When need reaches 0, validate:
    - 3-byte < 0x800, or 4-byte < 0x10000 (overlong): error.
    - 0xD800-0xDFFF (surrogate): error.
    - > 0x10FFFF: error.
    - Valid: cp=acc. Go to CALL.
  - Any other byte: truncation error, cp=REPLACEMENT. The byte is stored in the replay register (flag set) and decoded as a lead byte on the next LEAD visit. Go to CALL.
- CALL: call_start=1, call_c=cp held stable until accepted. On ~call_busy go to WAIT.
- WAIT: ret_stall=0. On ret_done, capture ret_data into out_mark and go to OUT.
- OUT: out_valid=1; outputs held stable while out_valid & ~out_ready. On out_ready go to LEAD (replay consumed first if pending).
- Errors: each error sets out_error=1 for that result and increments err_count once, saturating at all-ones.
- Throughput and latency:
  - Minimum latency with call_busy=0 and ret_done immediate: last byte accepted at cycle N, call_start at N+1, WAIT at N+2, out_valid at N+3.
  - No input bytes are accepted in CALL, WAIT or OUT.

Test Plan:
- Bytes 0x41; lookup returns 0x3 -> call_c=0x41, out_codepoint=0x41, out_mark=0x3, out_error=0, out_valid 3 cycles after accept.
- Bytes 0xC3 0xA9 -> call_c=0xE9. Bytes 0xF0 0x9F 0x98 0x80 -> call_c=0x1F600. Both out_error=0, err_count=0.
- Bytes 0xC0 0x80 -> two results, each codepoint 0xFFFD with out_error=1; err_count=2. Bytes 0xED 0xA0 0x80 -> one 0xFFFD (surrogate).
- Bytes 0xE2 0x82 0x41 -> 0xFFFD with out_error=1, then 0x41 from replay with out_error=0. in_ready stays 0 until the replayed byte is decoded.
- call_busy held 1 for 5 cycles and out_ready low 4 cycles -> call_c and outputs stable, in_ready=0 throughout, exactly one call issued.
- resetn pulsed low while in WAIT, then ret_done=1 arrives -> all outputs at reset values, ret_stall=1, no out_valid, err_count=0.
